adc_row_col_decoder_dem: RTL and testbench
==========================================

Name: adc_row_col_decoder_dem

Overview:
Parametrised, registered successor of the capacitor-matrix binary-to-thermometer decoder. It drives the row, column and binary-cell controls of a ROWS x COLS unit-capacitor array plus BINCAP_BITS binary cells in the SAR DAC. It adds dynamic element matching (DEM): a row-rotation pointer, advanced once per conversion, moves the starting row of the thermometer fill so mismatch errors are spread across rows. Outputs are registered, giving one cycle of latency.

Parameters:
ROWS, 16, matrix rows; power of two, >=2; ROW_BITS = clog2(ROWS)
COLS, 32, matrix columns; power of two, >=2; COL_BITS = clog2(COLS)
BINCAP_BITS, 3, binary cells below the unit matrix
DATA_W, ROW_BITS+COL_BITS+BINCAP_BITS, code width (localparam, 12 at defaults)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
data_in  in  DATA_W  SAR code: [DATA_W-1 -: ROW_BITS]=row r, next COL_BITS=col c, [BINCAP_BITS-1:0]=bincap
data_valid_in  in  1  accept data_in this cycle
conv_done_in  in  1  end-of-conversion pulse; advances DEM pointer
dem_mode_in  in  2  00 off, 01 rotate-by-1, 10 data-weighted (DWA), 11 treated as 00
row_out_n  out  ROWS  active-low partial-row select
rowon_out_n  out  ROWS  active-low full-row-on
rowoff_out_n  out  ROWS  active-low row-off
col_out_n  out  COLS  active-low column thermometer for partial row
col_out  out  COLS  ~col_out_n
bincap_out_n  out  BINCAP_BITS  ~bincap
c0p_out_n  out  1  constant 0
c0n_out_n  out  1  constant 1
valid_out  out  1  outputs updated this cycle
dem_ptr_out  out  ROW_BITS  current rotation pointer (debug)

Behaviour:
- All arithmetic on row indices is modulo ROWS (natural ROW_BITS wrap).
- Decode with pointer ptr: full rows are i with (i-ptr) mod ROWS < r; partial row p=(ptr+r) mod ROWS.
- rowon_out_n[i]=0 iff i is a full row; row_out_n[i]=0 iff i==p; rowoff_out_n = ~(row_out_n & rowon_out_n).
- Serpentine direction is chosen by the physical row p, not by r. For even p: col_out_n = {COLS{1}} << (c+1), so the low c+1 bits are 0. For odd p: col_out_n = {COLS{1}} >> (c+1), so the high c+1 bits are 0.
- On data_valid_in, data_in is decoded with the current ptr. All outputs register at the next edge, and valid_out pulses high for exactly 1 cycle. Without data_valid_in, outputs hold and valid_out=0.
- last_row register: captures r on each data_valid_in.
- On conv_done_in: mode 01 sets ptr<=ptr+1; mode 10 sets ptr<=ptr+last_row_eff; modes 00/11 hold ptr. last_row_eff is r from data_in if data_valid_in is high in the same cycle, otherwise last_row.
- If data_valid_in and conv_done_in are both high, the data is decoded with the OLD ptr; the new ptr applies from the next accepted code.
- A change of dem_mode_in takes effect at the next conv_done_in only. ptr is never cleared by the mode change.
- Reset outputs equal the decode of code 0 with ptr=0: row_out_n=~1, rowon_out_n=all 1, rowoff_out_n=1, col_out_n=~1, col_out=1, bincap_out_n=all 1, valid_out=0.
- Reset also clears ptr=0 and last_row=0.
- Reset mid-conversion wins over data_valid_in and conv_done_in in the same cycle.

Decomposition:
- Package adc_dec_pkg holds the DEM_OFF/DEM_ROT/DEM_DWA mode constants and a clog2 function.
- One combinational sub-module, adc_serpentine_col_decoder (inputs c and the parity of p, output col_out_n), is reused across decoder variants.
- The rotator and pointer stay in the top level.

Test Plan:
1. Reset for 2 cycles -> row_out_n=FFFE, rowon_out_n=FFFF, rowoff_out_n=0001, col_out_n=FFFFFFFE, bincap_out_n=7, valid_out=0, dem_ptr_out=0.
2. Mode 00, data_in=0x345 (r=3, c=8, bin=5) -> next cycle row_out_n=FFF7, rowon_out_n=FFF8, rowoff_out_n=000F, col_out_n=007FFFFF, bincap_out_n=2, valid_out 1-cycle pulse.
3. Mode 01, 3 conv_done pulses then data_in=0x100 (r=1, c=0) -> ptr=3, p=4 even: row_out_n=FFEF, rowon_out_n=FFF7, rowoff_out_n=0018, col_out_n=FFFFFFFE.
4. Wrap: mode 01, ptr=15, data_in=0x200 (r=2, c=0) -> full rows 15 and 0, p=1 odd: rowon_out_n=7FFE, row_out_n=FFFD, col_out_n=7FFFFFFF.
5. DWA: mode 10, ptr=0, data_in=0xA00 with conv_done_in in the same cycle -> decode uses ptr 0 (rowon_out_n=FC00), ptr becomes 10. A second conv_done with no new data -> ptr=4 (20 mod 16).
6. ptr=7, rst asserted together with data_valid_in and conv_done_in -> next cycle shows reset values, valid_out=0, dem_ptr_out=0.

Source files
------------

// File: rtl/adc_dec_pkg.sv
// ============================================================================
//  Module      : adc_dec_pkg
//  Description : Shared DEM mode encodings and width helper for the DAC decoders
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_dec_pkg;

    localparam logic [1:0] DEM_OFF = 2'b00;
    localparam logic [1:0] DEM_ROT = 2'b01;
    localparam logic [1:0] DEM_DWA = 2'b10;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_serpentine_col_decoder.sv
// ============================================================================
//  Module      : adc_serpentine_col_decoder
//  Description : Active-low column thermometer whose fill direction follows
//                the parity of the physical partial row (serpentine layout)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_serpentine_col_decoder
    import adc_dec_pkg::*;
#(
    parameter int COLS = 32,
    localparam int COL_BITS = clog2(COLS)
) (
    input  logic [COL_BITS-1:0] c,
    input  logic                p_odd,
    output logic [COLS-1:0]     col_out_n
);

    localparam logic [COLS-1:0] c_all_ones = '1;

    // c+1 can reach COLS, so the shift amount needs one extra bit
    logic [COL_BITS:0] w_shamt;

    assign w_shamt   = {1'b0, c} + (COL_BITS+1)'(1);
    assign col_out_n = p_odd ? (c_all_ones >> w_shamt) : (c_all_ones << w_shamt);

endmodule

`default_nettype wire

// File: rtl/adc_row_col_decoder_dem.sv
// ============================================================================
//  Module      : adc_row_col_decoder_dem
//  Description : Registered row/column/binary-cell decoder for the SAR DAC
//                capacitor matrix with row-rotation dynamic element matching
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_row_col_decoder_dem
    import adc_dec_pkg::*;
#(
    parameter int ROWS        = 16,
    parameter int COLS        = 32,
    parameter int BINCAP_BITS = 3,
    localparam int ROW_BITS   = clog2(ROWS),
    localparam int COL_BITS   = clog2(COLS),
    localparam int DATA_W     = ROW_BITS + COL_BITS + BINCAP_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   data_valid_in,
    input  logic                   conv_done_in,
    input  logic [1:0]             dem_mode_in,
    output logic [ROWS-1:0]        row_out_n,
    output logic [ROWS-1:0]        rowon_out_n,
    output logic [ROWS-1:0]        rowoff_out_n,
    output logic [COLS-1:0]        col_out_n,
    output logic [COLS-1:0]        col_out,
    output logic [BINCAP_BITS-1:0] bincap_out_n,
    output logic                   c0p_out_n,
    output logic                   c0n_out_n,
    output logic                   valid_out,
    output logic [ROW_BITS-1:0]    dem_ptr_out
);

    // Decode of code 0 with pointer 0
    localparam logic [ROWS-1:0] c_row_rst    = {{(ROWS-1){1'b1}}, 1'b0};
    localparam logic [ROWS-1:0] c_rowoff_rst = {{(ROWS-1){1'b0}}, 1'b1};
    localparam logic [COLS-1:0] c_col_n_rst  = {{(COLS-1){1'b1}}, 1'b0};

    logic [ROW_BITS-1:0]    w_r;
    logic [COL_BITS-1:0]    w_c;
    logic [BINCAP_BITS-1:0] w_bin;
    logic [ROW_BITS-1:0]    w_p;
    logic [ROW_BITS-1:0]    w_last_row_eff;
    logic [ROWS-1:0]        w_row_n;
    logic [ROWS-1:0]        w_rowon_n;
    logic [COLS-1:0]        w_col_n;

    logic [ROW_BITS-1:0]    r_ptr;
    logic [ROW_BITS-1:0]    r_last_row;
    logic [ROWS-1:0]        r_row_n;
    logic [ROWS-1:0]        r_rowon_n;
    logic [ROWS-1:0]        r_rowoff_n;
    logic [COLS-1:0]        r_col_n;
    logic [BINCAP_BITS-1:0] r_bin_n;
    logic                   r_valid;

    assign w_r   = data_in[DATA_W-1 -: ROW_BITS];
    assign w_c   = data_in[DATA_W-1-ROW_BITS -: COL_BITS];
    assign w_bin = data_in[BINCAP_BITS-1:0];
    assign w_p   = r_ptr + w_r;

    // A code arriving with the pulse counts as the last code of this conversion
    assign w_last_row_eff = data_valid_in ? w_r : r_last_row;

    // Rows are full when their distance past the pointer is below r
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [ROW_BITS-1:0] w_rel;
        assign w_rel         = ROW_BITS'(gi) - r_ptr;
        assign w_rowon_n[gi] = !(w_rel < w_r);
        assign w_row_n[gi]   = (ROW_BITS'(gi) != w_p);
    end

    adc_serpentine_col_decoder #(
        .COLS (COLS)
    ) u_col_dec (
        .c         (w_c),
        .p_odd     (w_p[0]),
        .col_out_n (w_col_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_last_row <= '0;
            r_row_n    <= c_row_rst;
            r_rowon_n  <= '1;
            r_rowoff_n <= c_rowoff_rst;
            r_col_n    <= c_col_n_rst;
            r_bin_n    <= '1;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= data_valid_in;
            if (data_valid_in) begin
                r_row_n    <= w_row_n;
                r_rowon_n  <= w_rowon_n;
                r_rowoff_n <= ~(w_row_n & w_rowon_n);
                r_col_n    <= w_col_n;
                r_bin_n    <= ~w_bin;
                r_last_row <= w_r;
            end
            if (conv_done_in) begin
                case (dem_mode_in)
                    DEM_ROT: r_ptr <= r_ptr + ROW_BITS'(1);
                    DEM_DWA: r_ptr <= r_ptr + w_last_row_eff;
                    default: r_ptr <= r_ptr;
                endcase
            end
        end
    end

    assign row_out_n    = r_row_n;
    assign rowon_out_n  = r_rowon_n;
    assign rowoff_out_n = r_rowoff_n;
    assign col_out_n    = r_col_n;
    assign col_out      = ~r_col_n;
    assign bincap_out_n = r_bin_n;
    assign c0p_out_n    = 1'b0;
    assign c0n_out_n    = 1'b1;
    assign valid_out    = r_valid;
    assign dem_ptr_out  = r_ptr;

endmodule

`default_nettype wire

// File: tb/tb_adc_row_col_decoder_dem.sv
// ============================================================================
//  Module      : tb_adc_row_col_decoder_dem
//  Description : Scoreboard bench for the DEM row/column decoder at defaults
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_row_col_decoder_dem;

    logic        clk;
    logic        rst;
    logic [11:0] data_in;
    logic        data_valid_in;
    logic        conv_done_in;
    logic [1:0]  dem_mode_in;
    logic [15:0] row_out_n;
    logic [15:0] rowon_out_n;
    logic [15:0] rowoff_out_n;
    logic [31:0] col_out_n;
    logic [31:0] col_out;
    logic [2:0]  bincap_out_n;
    logic        c0p_out_n;
    logic        c0n_out_n;
    logic        valid_out;
    logic [3:0]  dem_ptr_out;

    typedef struct packed {
        logic [15:0] row_n;
        logic [15:0] rowon_n;
        logic [15:0] rowoff_n;
        logic [31:0] col_n;
        logic [31:0] col;
        logic [2:0]  bin_n;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fails;

    adc_row_col_decoder_dem #(
        .ROWS        (16),
        .COLS        (32),
        .BINCAP_BITS (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .conv_done_in  (conv_done_in),
        .dem_mode_in   (dem_mode_in),
        .row_out_n     (row_out_n),
        .rowon_out_n   (rowon_out_n),
        .rowoff_out_n  (rowoff_out_n),
        .col_out_n     (col_out_n),
        .col_out       (col_out),
        .bincap_out_n  (bincap_out_n),
        .c0p_out_n     (c0p_out_n),
        .c0n_out_n     (c0n_out_n),
        .valid_out     (valid_out),
        .dem_ptr_out   (dem_ptr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e, input string tag);
        chk({tag, " row_out_n"},    32'(row_out_n),    32'(e.row_n));
        chk({tag, " rowon_out_n"},  32'(rowon_out_n),  32'(e.rowon_n));
        chk({tag, " rowoff_out_n"}, 32'(rowoff_out_n), 32'(e.rowoff_n));
        chk({tag, " col_out_n"},    col_out_n,         e.col_n);
        chk({tag, " col_out"},      col_out,           e.col);
        chk({tag, " bincap_out_n"}, 32'(bincap_out_n), 32'(e.bin_n));
    endtask

    // Monitor: every valid_out cycle must consume exactly one expected decode
    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_valid: valid_out=1 with no pending expectation");
            end else begin
                chk_all(exp_q.pop_front(), "decode");
            end
        end
    end

    // One stimulus cycle; a valid code queues its expected decode
    task automatic drive(input logic valid, input logic [11:0] data, input logic done, input exp_t e);
        data_valid_in = valid;
        data_in       = data;
        conv_done_in  = done;
        if (valid) exp_q.push_back(e);
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
        conv_done_in  = 1'b0;
        data_in       = '0;
    endtask

    task automatic pulse_done(input int n);
        exp_t none;
        none = '0;
        for (int k = 0; k < n; k++) drive(1'b0, 12'h000, 1'b1, none);
    endtask

    localparam exp_t c_rst_exp   = '{16'hFFFE, 16'hFFFF, 16'h0001, 32'hFFFFFFFE, 32'h00000001, 3'd7};
    localparam exp_t c_e345      = '{16'hFFF7, 16'hFFF8, 16'h000F, 32'h007FFFFF, 32'hFF800000, 3'd2};
    localparam exp_t c_e100_p3   = '{16'hFFEF, 16'hFFF7, 16'h0018, 32'hFFFFFFFE, 32'h00000001, 3'd7};
    localparam exp_t c_e200_p15  = '{16'hFFFD, 16'h7FFE, 16'h8003, 32'h7FFFFFFF, 32'h80000000, 3'd7};
    localparam exp_t c_ea00_p0   = '{16'hFBFF, 16'hFC00, 16'h07FF, 32'hFFFFFFFE, 32'h00000001, 3'd7};

    initial begin
        exp_t none;
        none          = '0;
        n_checks      = 0;
        n_fails       = 0;
        rst           = 1'b1;
        data_in       = '0;
        data_valid_in = 1'b0;
        conv_done_in  = 1'b0;
        dem_mode_in   = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all(c_rst_exp, "reset");
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset dem_ptr_out", 32'(dem_ptr_out), 32'd0);
        chk("c0p_out_n", 32'(c0p_out_n), 32'd0);
        chk("c0n_out_n", 32'(c0n_out_n), 32'd1);

        // Mode off, plain decode, then outputs must hold
        @(posedge clk); #1;
        drive(1'b1, 12'h345, 1'b0, c_e345);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold row_out_n", 32'(row_out_n), 32'hFFF7);
        chk("hold valid_out", 32'(valid_out), 32'd0);
        pulse_done(2);
        chk("mode00 ptr hold", 32'(dem_ptr_out), 32'd0);

        // Rotate-by-1
        dem_mode_in = 2'b01;
        pulse_done(3);
        chk("rot ptr=3", 32'(dem_ptr_out), 32'd3);
        drive(1'b1, 12'h100, 1'b0, c_e100_p3);

        // Wrap around the top row
        pulse_done(12);
        chk("rot ptr=15", 32'(dem_ptr_out), 32'd15);
        drive(1'b1, 12'h200, 1'b0, c_e200_p15);
        pulse_done(1);
        chk("rot ptr wrap 0", 32'(dem_ptr_out), 32'd0);

        // DWA: same-cycle code decodes with the old pointer
        dem_mode_in = 2'b10;
        drive(1'b1, 12'hA00, 1'b1, c_ea00_p0);
        chk("dwa ptr=10", 32'(dem_ptr_out), 32'd10);
        pulse_done(1);
        chk("dwa ptr=4", 32'(dem_ptr_out), 32'd4);
        dem_mode_in = 2'b11;
        pulse_done(1);
        chk("mode11 ptr hold", 32'(dem_ptr_out), 32'd4);

        // Reset wins over valid and conv_done in the same cycle
        dem_mode_in = 2'b01;
        pulse_done(3);
        chk("rot ptr=7", 32'(dem_ptr_out), 32'd7);
        rst           = 1'b1;
        data_valid_in = 1'b1;
        data_in       = 12'h345;
        conv_done_in  = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        data_valid_in = 1'b0;
        conv_done_in  = 1'b0;
        data_in       = '0;
        @(negedge clk);
        chk_all(c_rst_exp, "midreset");
        chk("midreset valid_out", 32'(valid_out), 32'd0);
        chk("midreset dem_ptr_out", 32'(dem_ptr_out), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
